// File: rtl/karatsuba_op_sequencer.sv
// Operand-issue / result-capture stage for the iterative 32x32 Karatsuba multiplier.
// Holds operands stable, pulses the multiplier reset, enables it for ITER_CYCLES
// cycles, then captures and offers the 64-bit product downstream.
// Optional feature macro: KARATSUBA_ZERO_BYPASS_EN (zero operand skips the multiplier).
module karatsuba_op_sequencer #(
    parameter int unsigned ITER_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_c,
    output logic        mul_rst,
    output logic        mul_enable,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(ITER_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ITER_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     a_q, b_q;
    logic [63:0]     out_c_q;
    logic            out_valid_q;
    logic            accept;
    logic            bypass;
    logic            run_last;

`ifdef KARATSUBA_ZERO_BYPASS_EN
    // A zero operand makes the product trivially zero; skip the multiplier.
    assign bypass = (in_a == 32'd0) || (in_b == 32'd0);
`else
    assign bypass = 1'b0;
`endif

    assign in_ready   = !rst && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    assign accept     = in_valid && in_ready;
    assign run_last   = (state_q == StRun) && (cnt_q == CntLast);
    assign mul_rst    = rst || (state_q == StLoad);
    assign mul_enable = !rst && (state_q == StRun);
    assign busy       = (state_q == StLoad) || (state_q == StRun);
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign out_c      = out_c_q;
    assign out_valid  = out_valid_q;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = bypass ? StHold : StLoad;
            end
            StLoad: state_d = StRun;
            StRun: begin
                if (cnt_q == CntLast) state_d = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    if (accept) state_d = bypass ? StHold : StLoad;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (state_q == StLoad) begin
                cnt_q <= '0;
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Downstream consumption clears first; a same-edge bypass accept re-arms it.
            if ((state_q == StHold) && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (run_last) begin
                out_c_q     <= mul_c;
                out_valid_q <= 1'b1;
            end else if (accept && bypass) begin
                out_c_q     <= '0;
                out_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_op_sequencer.sv
// Directed bench: default instance (ITER_CYCLES=3) plus an ITER_CYCLES=1 instance,
// each driven by a behavioural iterative-multiplier model.
module tb_karatsuba_op_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- ITER_CYCLES = 3 instance ----------------
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, mul_a, mul_b;
    logic [63:0] out_c, mul_c;
    logic        mul_rst, mul_enable, busy;
    int          mcnt;
    int          en_cnt, mrst_cnt;

    karatsuba_op_sequencer #(.ITER_CYCLES(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .mul_rst   (mul_rst),
        .mul_enable(mul_enable),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .busy      (busy)
    );

    // Multiplier model: product valid only during its final enabled cycle or later.
    always @(posedge clk) begin
        if (mul_rst) mcnt <= 0;
        else if (mul_enable) mcnt <= mcnt + 1;
    end
    assign mul_c = (mcnt >= 2) ? (64'(mul_a) * 64'(mul_b)) : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(negedge clk) begin
        if (mul_enable) en_cnt++;
        if (mul_rst) mrst_cnt++;
    end

    // ---------------- ITER_CYCLES = 1 instance ----------------
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_a1, in_b1, mul_a1, mul_b1;
    logic [63:0] out_c1, mul_c1;
    logic        mul_rst1, mul_enable1, busy1;
    int          mcnt1;
    int          en_cnt1;

    karatsuba_op_sequencer #(.ITER_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_c     (out_c1),
        .mul_rst   (mul_rst1),
        .mul_enable(mul_enable1),
        .mul_a     (mul_a1),
        .mul_b     (mul_b1),
        .mul_c     (mul_c1),
        .busy      (busy1)
    );

    always @(posedge clk) begin
        if (mul_rst1) mcnt1 <= 0;
        else if (mul_enable1) mcnt1 <= mcnt1 + 1;
    end
    assign mul_c1 = (mcnt1 >= 0 && mul_enable1) ? (64'(mul_a1) * 64'(mul_b1))
                                                : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(negedge clk) begin
        if (mul_enable1) en_cnt1++;
    end

    // Waits up to 20 edges for out_valid; returns edges elapsed since the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    // Issue one op from IDLE, then check latency, pulse counts and product.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_c, input int exp_lat,
                         input int exp_en, input int exp_rst);
        int lat;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        en_cnt = 0;
        mrst_cnt = 0;
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out_c"}, out_c, exp_c);
        check({tag, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
        check({tag, "_rst_cycles"}, 64'(mrst_cnt), 64'(exp_rst));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_consumed"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic saw_valid;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; in_a1 = '0; in_b1 = '0;

        // Reset
        repeat (3) step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mul_rst", 64'(mul_rst), 64'd1);
        check("rst_mul_enable", 64'(mul_enable), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_out_c", out_c, 64'd0);
        check("post_rst_mul_enable", 64'(mul_enable), 64'd0);
        check("post_rst_mul_rst", 64'(mul_rst), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_mul_a", 64'(mul_a), 64'd0);

        // Single op at defaults
        do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 3, 1);

        // Backpressure then back-to-back
        in_a = 32'h0001_0000; in_b = 32'h0001_0000; in_valid = 1'b1;
        step();
        in_a = 32'h8000_0000; in_b = 32'h0000_0002; // held by upstream, must be ignored
        check("bp_busy", 64'(busy), 64'd1);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_c_stable", out_c, 64'h0000_0001_0000_0000);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            step();
        end
        check("bp_mul_a_held", 64'(mul_a), 64'h0001_0000);
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_out_valid_drop", 64'(out_valid), 64'd0);
        check("b2b_load_mul_rst", 64'(mul_rst), 64'd1);
        check("b2b_mul_a", 64'(mul_a), 64'h8000_0000);
        wait_valid(lat);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_out_c", out_c, 64'h0000_0001_0000_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-RUN
        in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step(); // second RUN cycle
        check("midrun_enable", 64'(mul_enable), 64'd1);
        rst = 1'b1;
        #1;
        check("midrun_rst_enable", 64'(mul_enable), 64'd0);
        check("midrun_rst_in_ready", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("midrun_in_ready", 64'(in_ready), 64'd1);
        check("midrun_busy", 64'(busy), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) saw_valid = 1'b1;
            step();
        end
        check("midrun_no_valid", 64'(saw_valid), 64'd0);
        do_op("three_five", 32'd3, 32'd5, 64'd15, 4, 3, 1);

        // Zero operand
`ifdef KARATSUBA_ZERO_BYPASS_EN
        do_op("zero", 32'd0, 32'h1234_5678, 64'd0, 0, 0, 0);
`else
        do_op("zero", 32'd0, 32'h1234_5678, 64'd0, 4, 3, 1);
`endif

        // ITER_CYCLES = 1
        in_a1 = 32'd7; in_b1 = 32'd6; in_valid1 = 1'b1;
        #1;
        check("it1_in_ready", 64'(in_ready1), 64'd1);
        en_cnt1 = 0;
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            step();
            lat++;
        end
        check("it1_latency", 64'(lat), 64'd2);
        check("it1_out_c", out_c1, 64'd42);
        check("it1_en_cycles", 64'(en_cnt1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
